instruction_fetch_pipe: RTL and testbench
=========================================

INSTRUCTION_FETCH_PIPE -- requirements
Module: instruction_fetch_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC/instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the PC value after reset.
REQ-003 The block SHALL have parameter PC_INC, default 1, meaning the PC step per fetch (word-addressed memory).
REQ-004 The block SHALL have parameter FQ_DEPTH, default 2, meaning fetch-queue entries (power of 2, ≥2).
REQ-005 The block SHALL have parameter NOP, default 32'h00000013, meaning the bubble instruction.
REQ-006 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  asynchronous, active-low reset
 PCSrcE  in  1  redirect request from execute
 PCTarget  in  XLEN  redirect target
 StallD  in  1  decode not accepting; hold IF/ID
 FlushD  in  1  replace IF/ID with bubble
 imem_req  out  1  fetch request valid
 imem_addr  out  XLEN  fetch address
 imem_ready  in  1  memory accepts request this cycle
 imem_rvalid  in  1  response valid, in request order, latency ≥1
 imem_rdata  in  XLEN  response instruction
 IF_ID_IR  out  XLEN  registered instruction
 IF_ID_PC  out  XLEN  registered PC of IF_ID_IR
 IF_ID_PCPlus  out  XLEN  IF_ID_PC + PC_INC
 IF_ID_valid  out  1  IF_ID_IR is a real instruction

Function
REQ-007 Request accepted = imem_req & imem_ready; on acceptance PC SHALL advance by PC_INC (modulo 2^XLEN wrap).
REQ-008 imem_addr SHALL equal the PC register; imem_req SHALL be high iff outstanding + queue occupancy < FQ_DEPTH and PCSrcE is low.
REQ-009 The outstanding counter SHALL increment on acceptance, decrement on imem_rvalid, and be unchanged when both occur.
REQ-010 Each accepted request SHALL have its PC pushed to a PC FIFO; on a non-dropped imem_rvalid, {PC, imem_rdata} SHALL be written to the fetch queue.
REQ-011 The fetch queue SHALL never overflow; reserving slots via REQ-008 guarantees it.
REQ-012 When StallD is low, IF/ID SHALL load the queue head (valid=1) and pop it, or load a bubble (IR=NOP, valid=0, PC unchanged) if the queue is empty.
REQ-013 A response arriving while the queue is empty and StallD is low SHALL NOT bypass to IF/ID the same cycle (one-cycle minimum queue latency).
REQ-014 When StallD is high and FlushD/PCSrcE are low, IF/ID, the queue head and occupancy SHALL hold; responses still fill the queue.
REQ-015 On PCSrcE high: PC SHALL load PCTarget next cycle; the queue SHALL be emptied; IF/ID SHALL become a bubble; drop counter SHALL load the post-update outstanding count; no request is issued that cycle.
REQ-016 While drop counter > 0, each imem_rvalid SHALL decrement it and be discarded, with its PC-FIFO entry popped.
REQ-017 FlushD high SHALL make IF/ID a bubble next cycle, with priority over StallD; queue is unaffected unless PCSrcE is also high.
REQ-018 A second PCSrcE while drops are pending SHALL reload drop counter with the current outstanding count; the target of the last redirect wins.
REQ-019 IF_ID_PCPlus SHALL be computed from IF_ID_PC, width XLEN, wrapping.

Reset
REQ-020 While rst is low: PC=RESET_PC, outstanding=0, drop=0, queue and PC FIFO empty, IF_ID_IR=NOP, IF_ID_PC=0, IF_ID_PCPlus=PC_INC, IF_ID_valid=0, imem_req=0.
REQ-021 Assertion mid-operation SHALL abort all in-flight state; responses arriving after deassertion with outstanding=0 SHALL be ignored.
REQ-022 The first request SHALL be issued on the first rising edge after rst deasserts, at address RESET_PC.

Verification
REQ-023 Reset release, imem_ready=1, 1-cycle rvalid, rdata=addr+0x100 -> IF_ID_PC 0,1,2,... with IR 0x100,0x101,..., valid=1 from cycle 3.
REQ-024 imem_ready=0 for 5 cycles -> imem_addr holds, IF_ID_valid=0, IR=0x13, PC does not advance.
REQ-025 StallD high for 4 cycles in steady stream -> IF/ID holds; imem_req drops once 2 entries occupied; no instruction lost or duplicated after release.
REQ-026 PCSrcE with PCTarget=0x40 while 2 requests outstanding -> both responses discarded, next IF_ID_PC=0x40, one bubble in IF/ID.
REQ-027 FlushD with StallD both high -> IF_ID_valid=0 next cycle, queue contents emitted in order afterwards.
REQ-028 rst asserted with 1 outstanding, rvalid arriving after release -> ignored, first IF_ID_PC=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pipe.sv
// Instruction fetch stage: PC, request issue, response queue and IF/ID register.
// Redirects discard in-flight responses through a drop counter.
module instruction_fetch_pipe #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int PC_INC = 1,
  parameter int FQ_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_ID_IR,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_PCPlus,
  output logic            IF_ID_valid
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } if_id_t;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   out_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   occ_q;
  logic [AW-1:0]   pf_rd;
  logic [AW-1:0]   pf_wr;
  logic [AW-1:0]   fq_rd;
  logic [AW-1:0]   fq_wr;
  logic [XLEN-1:0] pf_mem [FQ_DEPTH];
  if_id_t          fq_mem [FQ_DEPTH];

  logic          accept;
  logic          rsp;
  logic          drop_rsp;
  logic          keep;
  logic          pop;
  logic [CW:0]   used;
  logic [CW-1:0] out_nxt;

  // Slots are reserved at issue time so the queue can never overflow.
  assign used = {1'b0, out_q} + {1'b0, occ_q};
  assign imem_req = rst & ~PCSrcE
                  & (used < (CW+1)'(FQ_DEPTH));
  assign imem_addr = pc_q;
  assign accept = imem_req & imem_ready;
  assign rsp = imem_rvalid & (out_q != '0);
  assign drop_rsp = rsp & (drop_q != '0);
  assign keep = rsp & ~drop_rsp & ~PCSrcE;
  assign pop = ~PCSrcE & ~FlushD & ~StallD
             & (occ_q != '0);
  assign out_nxt = out_q + CW'(accept) - CW'(rsp);
  assign IF_ID_PCPlus = IF_ID_PC + XLEN'(PC_INC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      pf_rd  <= '0;
      pf_wr  <= '0;
    end else begin
      out_q <= out_nxt;
      if (accept) pf_wr <= pf_wr + 1'b1;
      if (rsp) pf_rd <= pf_rd + 1'b1;
      if (PCSrcE) begin
        pc_q   <= PCTarget;
        drop_q <= out_nxt;
      end else begin
        if (accept) pc_q <= pc_q + XLEN'(PC_INC);
        if (drop_rsp) drop_q <= drop_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      fq_rd <= '0;
      fq_wr <= '0;
    end else if (PCSrcE) begin
      occ_q <= '0;
      fq_rd <= '0;
      fq_wr <= '0;
    end else begin
      occ_q <= occ_q + CW'(keep) - CW'(pop);
      if (keep) fq_wr <= fq_wr + 1'b1;
      if (pop) fq_rd <= fq_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pf_mem[pf_wr] <= pc_q;
    if (keep) fq_mem[fq_wr] <= '{pc: pf_mem[pf_rd], ir: imem_rdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_ID_IR    <= NOP;
      IF_ID_PC    <= '0;
      IF_ID_valid <= 1'b0;
    end else if (PCSrcE | FlushD) begin
      IF_ID_IR    <= NOP;
      IF_ID_valid <= 1'b0;
    end else if (!StallD) begin
      if (occ_q != '0) begin
        IF_ID_IR    <= fq_mem[fq_rd].ir;
        IF_ID_PC    <= fq_mem[fq_rd].pc;
        IF_ID_valid <= 1'b1;
      end else begin
        IF_ID_IR    <= NOP;
        IF_ID_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_pipe.sv
// Bench for instruction_fetch_pipe: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_instruction_fetch_pipe;

  localparam logic [31:0] NOP = 32'h13;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IF_ID_IR;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PCPlus;
  logic        IF_ID_valid;

  instruction_fetch_pipe dut (
    .clk(clk), .rst(rst),
    .PCSrcE(PCSrcE), .PCTarget(PCTarget),
    .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_IR(IF_ID_IR), .IF_ID_PC(IF_ID_PC),
    .IF_ID_PCPlus(IF_ID_PCPlus), .IF_ID_valid(IF_ID_valid)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h",
                  name, cyc, act, exp);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    int due;
  } mreq_t;

  // Reference model state
  int          m_out;
  int          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_pcq[$];
  ent_t        m_fq[$];
  logic [31:0] m_ir;
  logic [31:0] m_ifpc;
  logic        m_valid;
  logic        m_req;

  mreq_t mq[$];
  int    lat_min = 1;
  int    lat_max = 1;
  logic  inject_stale = 1'b0;
  logic  from_mem;

  task automatic model_reset();
    m_out = 0;
    m_drop = 0;
    m_pc = 32'h0;
    m_pcq.delete();
    m_fq.delete();
    m_ir = NOP;
    m_ifpc = 32'h0;
    m_valid = 1'b0;
    mq.delete();
  endtask

  task automatic step(input logic r, input logic rdy,
                      input logic s, input logic f,
                      input logic p, input logic [31:0] t);
    bit acc;
    bit rs;
    logic [31:0] pcv;
    ent_t e;
    @(negedge clk);
    rst = r;
    imem_ready = rdy;
    StallD = s;
    FlushD = f;
    PCSrcE = p;
    PCTarget = t;
    if (!r) model_reset();
    from_mem = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if (inject_stale) begin
      imem_rvalid = 1'b1;
      imem_rdata = 32'hdead;
      inject_stale = 1'b0;
    end else if (r && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mq[0].addr + 32'h100;
      from_mem = 1'b1;
    end
    m_req = r && (m_out + m_fq.size() < 2) && !p;
    #1;
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_ir", IF_ID_IR, m_ir);
    chk("if_id_pc", IF_ID_PC, m_ifpc);
    chk("if_id_pcplus", IF_ID_PCPlus, m_ifpc + 32'd1);
    chk("if_id_valid", IF_ID_valid, m_valid);
    if (IF_ID_valid === 1'b1)
      chk("ir_matches_pc", IF_ID_IR, IF_ID_PC + 32'h100);
    @(posedge clk);
    if (r) begin
      acc = m_req && rdy;
      rs = imem_rvalid && m_out > 0;
      if (p || f) begin
        m_ir = NOP;
        m_valid = 1'b0;
      end else if (!s) begin
        if (m_fq.size() > 0) begin
          e = m_fq.pop_front();
          m_ir = e.ir;
          m_ifpc = e.pc;
          m_valid = 1'b1;
        end else begin
          m_ir = NOP;
          m_valid = 1'b0;
        end
      end
      if (rs) begin
        pcv = m_pcq.pop_front();
        if (m_drop > 0) m_drop--;
        else if (!p) m_fq.push_back('{pc: pcv, ir: imem_rdata});
      end
      m_out = m_out + int'(acc) - int'(rs);
      if (p) begin
        m_fq.delete();
        m_drop = m_out;
        m_pc = t;
      end else if (acc) begin
        m_pcq.push_back(m_pc);
        mq.push_back('{addr: m_pc,
                       due: cyc + $urandom_range(lat_max, lat_min)});
        m_pc = m_pc + 32'd1;
      end
      if (from_mem) void'(mq.pop_front());
    end
    cyc++;
  endtask

  typedef struct {
    logic        ready;
    logic        stall;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd1};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd2};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd3};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd4};

    model_reset();
    repeat (3) step(0, 1, 0, 0, 0, 0);

    for (int k = 0; k < 9; k++) begin
      step(1, vt[k].ready, vt[k].stall, 0, 0, 0);
      #1;
      chk("tbl_req", {31'b0, m_req}, {31'b0, vt[k].exp_req});
      chk("tbl_valid", IF_ID_valid, vt[k].exp_valid);
      chk("tbl_pc", IF_ID_PC, vt[k].exp_pc);
      chk("tbl_ir", IF_ID_IR,
          vt[k].exp_valid ? vt[k].exp_pc + 32'h100 : NOP);
    end

    repeat (5) step(1, 0, 0, 0, 0, 0);
    repeat (6) step(1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 1, 0, 0, 0);
    repeat (8) step(1, 1, 0, 0, 0, 0);

    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && m_out != 2; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 32'h40);
    for (int i = 0; i < 30 && !m_valid; i++) step(1, 1, 0, 0, 0, 0);
    #1;
    chk("redirect_valid", IF_ID_valid, 1'b1);
    chk("redirect_pc", IF_ID_PC, 32'h40);
    chk("redirect_ir", IF_ID_IR, 32'h140);

    lat_min = 1;
    lat_max = 1;
    repeat (3) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    #1;
    chk("flush_stall_valid", IF_ID_valid, 1'b0);
    repeat (6) step(1, 1, 0, 0, 0, 0);

    lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      step(1, ($urandom_range(3, 0) != 0),
           ($urandom_range(4, 0) == 0),
           ($urandom_range(19, 0) == 0),
           ($urandom_range(24, 0) == 0),
           $urandom & 32'hff);
    end

    lat_min = 4;
    lat_max = 4;
    step(1, 1, 0, 1, 1, 32'h80);
    for (int i = 0; i < 10 && m_out == 0; i++) step(1, 1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    lat_min = 1;
    lat_max = 1;
    inject_stale = 1'b1;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !m_valid; i++) step(1, 1, 0, 0, 0, 0);
    #1;
    chk("rst_abort_valid", IF_ID_valid, 1'b1);
    chk("rst_abort_pc", IF_ID_PC, 32'h0);
    chk("rst_abort_ir", IF_ID_IR, 32'h100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
